// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants and helpers for the load/store access unit.
//   - RV32 funct3 encodings for loads/stores (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - byte lane count of the 32-bit data path
//   - FSM state encoding used by mem_io_access_unit
//   - funct3Legal(): legality of a funct3 for a load or a store
package mem_io_pkg;

    localparam int LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPT    = 3'd2,
        IO_WAIT = 3'd3,
        RESP    = 3'd4
    } accState_e;

    // Unsigned variants only exist for loads.
    function automatic logic funct3Legal(input logic isLoad, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = isLoad;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_io_access_unit_if.sv
// mem_io_access_unit_if: request/response, data RAM and MMIO signals of the
// access unit, bundled in one interface.
//   modport slave  : the access unit itself
//   modport master : the environment (pipeline, RAM, I/O bus)
// Signal names keep the _i/_o suffixes as seen from the access unit.
interface mem_io_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              is_load_i;
    logic              is_store_i;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;

    logic              mem_re_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    logic              io_re_o;
    logic              io_we_o;
    logic [3:0]        io_be_o;
    logic [ADDR_W-1:0] io_addr_o;
    logic [31:0]       io_wdata_o;
    logic [31:0]       io_rdata_i;
    logic              io_ready_i;

    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic              busy_o;

    modport slave (
        input  req_valid_i, is_load_i, is_store_i, funct3_i, addr_i, wdata_i,
        input  mem_rdata_i, io_rdata_i, io_ready_i,
        output req_ready_o,
        output mem_re_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output io_re_o, io_we_o, io_be_o, io_addr_o, io_wdata_o,
        output resp_valid_o, resp_rdata_o, resp_err_o, busy_o
    );

    modport master (
        output req_valid_i, is_load_i, is_store_i, funct3_i, addr_i, wdata_i,
        output mem_rdata_i, io_rdata_i, io_ready_i,
        input  req_ready_o,
        input  mem_re_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  io_re_o, io_we_o, io_be_o, io_addr_o, io_wdata_o,
        input  resp_valid_o, resp_rdata_o, resp_err_o, busy_o
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic of the access unit.
//   funct3    in  3   access size/sign
//   byteOff   in  2   low address bits (already aligned for half/word)
//   storeData in  32  store data, low bits significant
//   rawRdata  in  32  word returned by RAM or I/O
//   byteEn    out 4   lane enables
//   laneWdata out 32  store data replicated across lanes
//   loadData  out 32  selected lanes, sign/zero extended
module lsu_lane_align
    import mem_io_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] storeData,
    input  logic [31:0] rawRdata,
    output logic [3:0]  byteEn,
    output logic [31:0] laneWdata,
    output logic [31:0] loadData
);
    logic [31:0] shifted;

    always_comb begin
        shifted   = rawRdata >> {byteOff, 3'b000};
        byteEn    = 4'b1111;
        laneWdata = storeData;
        loadData  = shifted;
        case (funct3)
            F3_B, F3_BU: begin
                byteEn    = 4'b0001 << byteOff;
                laneWdata = {4{storeData[7:0]}};
                loadData  = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'b0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                byteEn    = 4'b0011 << {byteOff[1], 1'b0};
                laneWdata = {2{storeData[15:0]}};
                loadData  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'b0, shifted[15:0]};
            end
            default: begin
                byteEn    = 4'b1111;
                laneWdata = storeData;
                loadData  = shifted;
            end
        endcase
    end
endmodule

// File: rtl/mem_io_access_unit.sv
// mem_io_access_unit: RV32 load/store access unit between EX/MEM and the
// data RAM / MMIO bus. One response per accepted request.
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset (drops any access in flight)
//   bus      mem_io_access_unit_if.slave: request, RAM, I/O and response signals
// Build option: define MISALIGN_TRAP_EN to turn misaligned half/word accesses
// into error responses; otherwise the offending low address bits are cleared.
//
// state   | meaning
// IDLE    | ready for a request
// ISSUE   | RAM strobe cycle
// CAPT    | sample RAM read data
// IO_WAIT | I/O strobe held until ready or timeout
// RESP    | one-cycle response pulse
module mem_io_access_unit
    import mem_io_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter int                 IO_HI_W    = 22,
    parameter logic [IO_HI_W-1:0] IO_HI      = 22'h3FFFFF,
    parameter int                 IO_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    mem_io_access_unit_if.slave bus
);
    localparam int TMR_W = $clog2(IO_TIMEOUT + 1);

    accState_e         state, stateNext;
    logic              isLoadQ, isIoQ, errQ;
    logic [2:0]        funct3Q;
    logic [ADDR_W-1:0] addrQ, addrFix;
    logic [31:0]       wdataQ, rdataQ;
    logic [TMR_W-1:0]  ioTimer;

    logic              misTrap, reqOk, ioHit, ioTimeout;
    logic [3:0]        laneBe;
    logic [31:0]       laneWdata, loadData, rawRdata;

    // Misalignment either traps or is silently aligned down.
    always_comb begin
        addrFix = bus.addr_i;
        misTrap = 1'b0;
        if (bus.funct3_i[1:0] == 2'b01 && bus.addr_i[0]) begin
`ifdef MISALIGN_TRAP_EN
            misTrap = 1'b1;
`else
            addrFix[0] = 1'b0;
`endif
        end
        if (bus.funct3_i[1:0] == 2'b10 && bus.addr_i[1:0] != 2'b00) begin
`ifdef MISALIGN_TRAP_EN
            misTrap = 1'b1;
`else
            addrFix[1:0] = 2'b00;
`endif
        end
    end

    assign reqOk = (bus.is_load_i ^ bus.is_store_i)
                 && funct3Legal(bus.is_load_i, bus.funct3_i) && !misTrap;
    assign ioHit = (addrFix[ADDR_W-1 -: IO_HI_W] == IO_HI);
    assign ioTimeout = (ioTimer == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (!reqOk)     stateNext = RESP;
                    else if (ioHit) stateNext = IO_WAIT;
                    else            stateNext = ISSUE;
                end
            end
            ISSUE:   stateNext = isLoadQ ? CAPT : RESP;
            CAPT:    stateNext = RESP;
            IO_WAIT: if (bus.io_ready_i || ioTimeout) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request registers; the timeout timer counts down to its terminal value 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            isLoadQ <= 1'b0;
            isIoQ   <= 1'b0;
            errQ    <= 1'b0;
            funct3Q <= '0;
            addrQ   <= '0;
            wdataQ  <= '0;
            rdataQ  <= '0;
            ioTimer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        isLoadQ <= bus.is_load_i;
                        isIoQ   <= ioHit;
                        errQ    <= !reqOk;
                        funct3Q <= bus.funct3_i;
                        addrQ   <= addrFix;
                        wdataQ  <= bus.wdata_i;
                        rdataQ  <= '0;
                        ioTimer <= TMR_W'(IO_TIMEOUT - 1);
                    end
                end
                CAPT: rdataQ <= loadData;
                IO_WAIT: begin
                    if (bus.io_ready_i) begin
                        if (isLoadQ) rdataQ <= loadData;
                    end else if (ioTimeout) begin
                        errQ <= 1'b1;
                    end else begin
                        ioTimer <= ioTimer - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rawRdata = isIoQ ? bus.io_rdata_i : bus.mem_rdata_i;

    lsu_lane_align u_lane (
        .funct3    (funct3Q),
        .byteOff   (addrQ[1:0]),
        .storeData (wdataQ),
        .rawRdata  (rawRdata),
        .byteEn    (laneBe),
        .laneWdata (laneWdata),
        .loadData  (loadData)
    );

    logic inIssue, inIo, inResp;
    assign inIssue = (state == ISSUE);
    assign inIo    = (state == IO_WAIT);
    assign inResp  = (state == RESP);

    // Bus outputs are gated by their strobe so idle buses read as all-zero.
    assign bus.req_ready_o  = (state == IDLE);
    assign bus.busy_o       = (state != IDLE);

    assign bus.mem_re_o     = inIssue && isLoadQ;
    assign bus.mem_we_o     = inIssue && !isLoadQ;
    assign bus.mem_be_o     = inIssue ? laneBe : 4'b0000;
    assign bus.mem_addr_o   = inIssue ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata_o  = (inIssue && !isLoadQ) ? laneWdata : 32'h0;

    assign bus.io_re_o      = inIo && isLoadQ;
    assign bus.io_we_o      = inIo && !isLoadQ;
    assign bus.io_be_o      = inIo ? laneBe : 4'b0000;
    assign bus.io_addr_o    = inIo ? addrQ : '0;
    assign bus.io_wdata_o   = (inIo && !isLoadQ) ? laneWdata : 32'h0;

    assign bus.resp_valid_o = inResp;
    assign bus.resp_rdata_o = inResp ? rdataQ : 32'h0;
    assign bus.resp_err_o   = inResp && errQ;
endmodule

// File: tb/tb_mem_io_access_unit.sv
// tb_mem_io_access_unit: directed cases plus randomized loads/stores against
// a byte-level reference model with a shadow RAM and a programmable I/O device.
module tb_mem_io_access_unit;
    import mem_io_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    logic ramInit;
    always #5 clk = ~clk;

    mem_io_access_unit_if #(.ADDR_W(32)) bus ();

    mem_io_access_unit #(
        .ADDR_W(32), .IO_HI_W(22), .IO_HI(22'h3FFFFF), .IO_TIMEOUT(16)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (bus)
    );

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] devRam [64];
    logic [31:0] refRam [64];

    function automatic logic [31:0] seedWord(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous RAM device: read data appears the cycle after mem_re_o.
    always @(posedge clk) begin
        if (ramInit) begin
            for (int i = 0; i < 64; i++) devRam[i] <= seedWord(i);
        end else begin
            if (bus.mem_re_o) bus.mem_rdata_i <= devRam[bus.mem_addr_o[7:2]];
            if (bus.mem_we_o)
                for (int l = 0; l < 4; l++)
                    if (bus.mem_be_o[l])
                        devRam[bus.mem_addr_o[7:2]][8*l +: 8] <= bus.mem_wdata_o[8*l +: 8];
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: access rules applied bytewise to the shadow RAM.
    task automatic refTxn(
        input  logic ld, input logic st, input logic [2:0] f3,
        input  logic [31:0] addr, input logic [31:0] wdata,
        input  logic [31:0] ioVal, input int ioWait,
        output logic err, output logic [31:0] rdata, output int lat,
        output int memCyc, output int ioCyc, output logic [3:0] be,
        output logic [31:0] effA, output logic [31:0] wrep);
        int size, off;
        logic legal, mis, io, go;
        logic [31:0] word, mask;
        legal = (ld != st) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                               (ld && (f3 == 3'd4 || f3 == 3'd5)));
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        err = 1'b0; rdata = 32'h0; lat = 1; memCyc = 0; ioCyc = 0;
        be = 4'b0000; wrep = 32'h0; effA = addr; word = 32'h0;
        go = legal;
        if (!legal) err = 1'b1;
        if (legal && mis) begin
`ifdef MISALIGN_TRAP_EN
            err = 1'b1;
            go  = 1'b0;
`else
            effA = (size == 2) ? (addr & ~32'h1) : (addr & ~32'h3);
`endif
        end
        if (go) begin
            off = int'(effA[1:0]);
            for (int l = 0; l < 4; l++) begin
                be[l] = (l >= off) && (l < off + size);
                wrep[8*l +: 8] = wdata[8*(l % size) +: 8];
            end
            io = (effA >= 32'hFFFF_FC00);
            if (io) begin
                if (ioWait >= 1 && ioWait <= 16) begin
                    ioCyc = ioWait; lat = ioWait + 1; word = ioVal;
                end else begin
                    ioCyc = 16; lat = 17; err = 1'b1;
                end
            end else begin
                memCyc = 1;
                lat    = ld ? 3 : 2;
                word   = refRam[effA[7:2]];
                if (st)
                    for (int l = 0; l < 4; l++)
                        if (be[l]) refRam[effA[7:2]][8*l +: 8] = wrep[8*l +: 8];
            end
            if (ld && !err) begin
                mask  = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
                rdata = (word >> (8*off)) & mask;
                if (!f3[2] && size < 4 && rdata[8*size-1]) rdata = rdata | ~mask;
            end
        end
    endtask

    task automatic runTxn(
        input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] wdata,
        input int ioWait, input logic [31:0] ioVal,
        output logic [31:0] gotRd, output logic gotErr,
        output logic [3:0] gotBe, output logic [31:0] gotWd);
        logic eErr; logic [31:0] eRd, eA, eWd; logic [3:0] eBe;
        int eLat, eMem, eIo, gotLat, gotMem, gotIo, badReady;
        logic done;
        logic [31:0] gotAddr;
        refTxn(ld, st, f3, addr, wdata, ioVal, ioWait, eErr, eRd, eLat, eMem, eIo, eBe, eA, eWd);
        gotRd = 32'h0; gotErr = 1'b0; gotBe = 4'b0; gotWd = 32'h0; gotAddr = 32'h0;
        gotLat = 0; gotMem = 0; gotIo = 0; badReady = 0; done = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.is_load_i = ld; bus.is_store_i = st;
        bus.funct3_i = f3; bus.addr_i = addr; bus.wdata_i = wdata;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.addr_i  = $urandom;
        bus.wdata_i = $urandom;
        for (int c = 1; c <= 64 && !done; c++) begin
            if (bus.mem_re_o || bus.mem_we_o) begin
                gotMem++; gotBe = bus.mem_be_o; gotAddr = bus.mem_addr_o; gotWd = bus.mem_wdata_o;
            end
            if (bus.io_re_o || bus.io_we_o) begin
                gotIo++; gotBe = bus.io_be_o; gotAddr = bus.io_addr_o; gotWd = bus.io_wdata_o;
                bus.io_ready_i = (gotIo == ioWait);
                bus.io_rdata_i = ioVal;
            end else begin
                bus.io_ready_i = 1'b0;
            end
            if (bus.req_ready_o == bus.busy_o) badReady++;
            if (bus.resp_valid_o) begin
                done = 1'b1; gotLat = c; gotErr = bus.resp_err_o; gotRd = bus.resp_rdata_o;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.io_ready_i = 1'b0;
        checkVal("resp_seen", 32'(done), 32'd1);
        checkVal("latency", 32'(gotLat), 32'(eLat));
        checkVal("resp_err", 32'(gotErr), 32'(eErr));
        checkVal("resp_rdata", gotRd, eRd);
        checkVal("mem_strobes", 32'(gotMem), 32'(eMem));
        checkVal("io_strobes", 32'(gotIo), 32'(eIo));
        checkVal("ready_vs_busy", 32'(badReady), 32'd0);
        if (eMem + eIo > 0) begin
            checkVal("byte_en", 32'(gotBe), 32'(eBe));
            checkVal("bus_addr", gotAddr, (eMem > 0) ? (eA & ~32'h3) : eA);
            if (st) checkVal("bus_wdata", gotWd, eWd);
        end
        @(posedge clk); #1;
        checkVal("idle_after", {29'b0, bus.busy_o, bus.resp_valid_o, bus.req_ready_o}, 32'd1);
    endtask

    logic [31:0] rd, wd;
    logic        er;
    logic [3:0]  be;

    initial begin
        int respSeen;
        rstN = 1'b0; ramInit = 1'b1;
        bus.req_valid_i = 1'b0; bus.is_load_i = 1'b0; bus.is_store_i = 1'b0;
        bus.funct3_i = 3'b0; bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
        bus.io_rdata_i = 32'h0; bus.io_ready_i = 1'b0;
        for (int i = 0; i < 64; i++) refRam[i] = seedWord(i);
        repeat (3) @(posedge clk);
        #1;
        ramInit = 1'b0;
        checkVal("rst_ready", 32'(bus.req_ready_o), 32'd1);
        checkVal("rst_busy", 32'(bus.busy_o), 32'd0);
        checkVal("rst_resp", {30'b0, bus.resp_valid_o, bus.resp_err_o}, 32'd0);
        checkVal("rst_strobes", {28'b0, bus.mem_re_o, bus.mem_we_o, bus.io_re_o, bus.io_we_o}, 32'd0);
        checkVal("rst_be", {24'b0, bus.mem_be_o, bus.io_be_o}, 32'd0);
        checkVal("rst_rdata", bus.resp_rdata_o, 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        runTxn(1'b0, 1'b1, F3_W, 32'h0000_0100, 32'h80FF_7F01, 0, 32'h0, rd, er, be, wd);
        runTxn(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, 0, 32'h0, rd, er, be, wd);
        checkVal("lb_rdata", rd, 32'hFFFF_FF80);
        checkVal("lb_be", 32'(be), 32'h8);
        runTxn(1'b0, 1'b1, F3_H, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0, rd, er, be, wd);
        checkVal("sh_be", 32'(be), 32'hC);
        checkVal("sh_wdata", wd, 32'hABCD_ABCD);
        runTxn(1'b1, 1'b0, F3_W, 32'hFFFF_FC60, 32'h0, 5, 32'h0000_00A5, rd, er, be, wd);
        checkVal("io_lw_rdata", rd, 32'h0000_00A5);
        checkVal("io_lw_err", 32'(er), 32'd0);
        runTxn(1'b0, 1'b1, F3_W, 32'hFFFF_FC00, 32'h1111_2222, 0, 32'h0, rd, er, be, wd);
        checkVal("io_timeout_err", 32'(er), 32'd1);
        runTxn(1'b1, 1'b0, F3_W, 32'h0000_0006, 32'h0, 0, 32'h0, rd, er, be, wd);
        runTxn(1'b1, 1'b1, F3_W, 32'h0000_0010, 32'h0, 0, 32'h0, rd, er, be, wd);
        runTxn(1'b0, 1'b1, F3_BU, 32'h0000_0010, 32'h0, 0, 32'h0, rd, er, be, wd);

        // Reset while an I/O write is waiting.
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.is_load_i = 1'b0; bus.is_store_i = 1'b1;
        bus.funct3_i = F3_W; bus.addr_i = 32'hFFFF_FC04; bus.wdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("pre_rst_io_we", 32'(bus.io_we_o), 32'd1);
        rstN = 1'b0;
        #1;
        checkVal("mid_rst_strobes", {30'b0, bus.io_we_o, bus.io_re_o}, 32'd0);
        checkVal("mid_rst_ready", 32'(bus.req_ready_o), 32'd1);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        respSeen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid_o || !bus.req_ready_o) respSeen++;
        end
        checkVal("post_rst_quiet", 32'(respSeen), 32'd0);

        for (int n = 0; n < 160; n++) begin
            logic ld, st, io;
            logic [2:0] f3;
            logic [31:0] a;
            int w;
            ld = 1'($urandom_range(0, 1));
            st = !ld;
            if ($urandom_range(0, 9) == 0) begin
                ld = 1'($urandom_range(0, 1));
                st = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
            end else if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = F3_B;  1: f3 = F3_H;  2: f3 = F3_W;
                    3: f3 = F3_BU; default: f3 = F3_HU;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            io = ($urandom_range(0, 3) == 0);
            a  = io ? (32'hFFFF_FC00 | 32'($urandom_range(0, 1023)))
                    : 32'($urandom_range(0, 255));
            w  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 16));
            runTxn(ld, st, f3, a, $urandom, w, $urandom, rd, er, be, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
